// File: rtl/gpu_pkg.sv
// Shared types and helpers for the memory arbiter: FSM state encoding and
// the round-robin priority search used by rr_picker.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int unsigned MAX_CORES = 8;

  // Returns {found, index}: first set bit of req at or after ptr, wrapping at n.
  function automatic logic [3:0] rr_search(input logic [MAX_CORES-1:0] req,
                                           input logic [2:0]           ptr,
                                           input int unsigned          n);
    logic [3:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_CORES; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !res[3] && req[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational one-hot picker: grants the first requester at or after ptr.
module rr_picker
  import gpu_pkg::*;
#(
  parameter  int unsigned NUM_CORES     = 2,
  localparam int unsigned CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0]     req,
  input  logic [CORE_ID_WIDTH-1:0] ptr,
  output logic [NUM_CORES-1:0]     grant_onehot,
  output logic [CORE_ID_WIDTH-1:0] grant_idx
);

  logic [MAX_CORES-1:0] req_ext;
  logic [2:0]           ptr_ext;
  logic [3:0]           pick;

  // Widen inputs to the helper's fixed width and decode its result.
  always_comb begin
    req_ext                     = '0;
    req_ext[NUM_CORES-1:0]      = req;
    ptr_ext                     = '0;
    ptr_ext[CORE_ID_WIDTH-1:0]  = ptr;
    pick                        = rr_search(req_ext, ptr_ext, NUM_CORES);
    grant_idx                   = pick[CORE_ID_WIDTH-1:0];
    grant_onehot                = '0;
    if (pick[3]) begin
      grant_onehot[pick[CORE_ID_WIDTH-1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-ported memory among NUM_CORES cores.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: fixed priority (lowest index
// wins), no round-robin pointer.
module mem_arbiter
  import gpu_pkg::*;
#(
  parameter  int unsigned NUM_CORES     = 2,
  parameter  int unsigned DATA_WIDTH    = 8,
  parameter  int unsigned ADDR_WIDTH    = 4,
  localparam int unsigned CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            req_valid,
  output logic [NUM_CORES-1:0]            req_ready,
  input  logic [NUM_CORES-1:0]            req_write,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CORES-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_rdata,
  output logic                            mem_read_en,
  output logic                            mem_write_en,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_write_data,
  input  logic [DATA_WIDTH-1:0]           mem_read_data,
  output logic                            busy,
  output logic [CORE_ID_WIDTH-1:0]        grant_id
);

  arb_state_t               state_q, state_d;
  logic [CORE_ID_WIDTH-1:0] owner_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [CORE_ID_WIDTH-1:0] pick_ptr;
  logic [NUM_CORES-1:0]     grant_onehot;
  logic [CORE_ID_WIDTH-1:0] grant_idx;
  logic                     handshake;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [CORE_ID_WIDTH-1:0] rr_ptr;

  // Rotate priority to the core after the one just issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (state_q == ISSUE) begin
      rr_ptr <= (32'(owner_q) == NUM_CORES - 1) ? '0 : owner_q + 1'b1;
    end
  end

  assign pick_ptr = rr_ptr;
`endif

  rr_picker #(
    .NUM_CORES (NUM_CORES)
  ) u_picker (
    .req          (req_valid),
    .ptr          (pick_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake and combinational ready.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant_onehot;
        handshake = |req_valid;
        if (handshake) state_d = ISSUE;
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted request into the memory port, then pulse the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q        <= '0;
      write_q        <= 1'b0;
      grant_id       <= '0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      resp_valid     <= '0;
      rdata_q        <= '0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      resp_valid   <= '0;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            owner_q        <= grant_idx;
            grant_id       <= grant_idx;
            write_q        <= req_write[grant_idx];
            mem_addr       <= req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_write_data <= req_wdata[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            mem_read_en    <= !req_write[grant_idx];
            mem_write_en   <= req_write[grant_idx];
          end
        end
        ISSUE: resp_valid[owner_q] <= 1'b1;
        RESP:  if (!write_q) rdata_q <= mem_read_data;
        default: ;
      endcase
    end
  end

  // Memory data arrives during RESP, the same cycle resp_valid is high, so a
  // read response forwards it directly; rdata_q keeps it (and holds across
  // writes) for every other cycle.
  assign resp_rdata = (state_q == RESP && !write_q) ? mem_read_data : rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (NUM_CORES=2) with a synchronous-read
// memory model and a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 1;

  localparam logic [7:0] MEM_INIT [16] = '{
    8'h11, 8'h22, 8'h33, 8'hA5, 8'h44, 8'h55, 8'h66, 8'h77,
    8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0
  };

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_write, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata, mem_write_data;
  logic [DW-1:0]   mem_read_data = '0;
  logic            mem_read_en, mem_write_en, busy;
  logic [AW-1:0]   mem_addr;
  logic [CW-1:0]   grant_id;

  mem_arbiter #(
    .NUM_CORES  (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT: read data valid the cycle after mem_read_en.
  logic [7:0] mem [16] = MEM_INIT;
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= mem[mem_addr];
  end

  // Reference model: one access occupies 3 cycles from grant.
  logic [7:0] exp_mem [16] = MEM_INIT;
  int  m_age, m_ptr, m_owner, m_addr, m_wdata, m_rdata, m_gid;
  bit  m_write;
  int  checks = 0, passes = 0, cyc = 0;
  int  hs_id[$], hs_cyc[$];
  int  resp_seen [N];
  int  cool [N];
  logic [N-1:0] last_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < int'(N); k++) begin
      int i;
      i = (ptr + k) % int'(N);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_age = 0; m_ptr = 0; m_owner = 0; m_addr = 0; m_wdata = 0;
    m_rdata = 0; m_gid = 0; m_write = 1'b0;
  endtask

  // Check all outputs mid-cycle, advance the model, move to just past the edge.
  task automatic step();
    logic [N-1:0] exp_ready, exp_resp;
    int w;
    @(negedge clk);
    w = (m_age == 0 && reset) ? winner(req_valid, m_ptr) : -1;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(m_age != 0));
    check("mem_read_en", 32'(mem_read_en), 32'(m_age == 1 && !m_write));
    check("mem_write_en", 32'(mem_write_en), 32'(m_age == 1 && m_write));
    if (m_age == 1) begin
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_write) check("mem_write_data", 32'(mem_write_data), 32'(m_wdata));
    end
    exp_resp = '0;
    if (m_age == 2) exp_resp[m_owner] = 1'b1;
    check("resp_valid", 32'(resp_valid), 32'(exp_resp));
    if (m_age == 2 && !m_write) check("resp_rdata_read", 32'(resp_rdata), 32'(exp_mem[m_addr]));
    else                        check("resp_rdata_hold", 32'(resp_rdata), 32'(m_rdata));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    for (int i = 0; i < int'(N); i++) if (resp_valid[i] === 1'b1) resp_seen[i]++;
    last_ready = req_ready;
    if (!reset) begin
      model_reset();
    end else if (m_age == 0) begin
      if (w >= 0) begin
        m_owner = w; m_gid = w; m_write = req_write[w];
        m_addr  = int'(req_addr[w*AW +: AW]);
        m_wdata = int'(req_wdata[w*DW +: DW]);
        m_age   = 1;
        hs_id.push_back(w); hs_cyc.push_back(cyc);
      end
    end else if (m_age == 1) begin
      m_age = 2;
`ifndef MEM_ARB_FIXED_PRIO_EN
      m_ptr = (m_owner + 1) % int'(N);
`endif
      if (m_write) exp_mem[m_addr] = 8'(m_wdata);
    end else begin
      m_age = 0;
      if (!m_write) m_rdata = int'(exp_mem[m_addr]);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input bit wr, input int a, input int d);
    req_valid[c]           = 1'b1;
    req_write[c]           = wr;
    req_addr[c*AW +: AW]   = AW'(a);
    req_wdata[c*DW +: DW]  = DW'(d);
  endtask

  initial begin
    int base, r1;
    reset = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < int'(N); i++) begin resp_seen[i] = 0; cool[i] = 0; end
    model_reset();
    repeat (2) step();
    reset = 1'b1;
    step();

    // Single read of address 3 by core0.
    set_req(0, 1'b0, 3, 0);
    step();
    req_valid = '0;
    repeat (2) step();

    // Core1 writes 0x3C to address 8, then reads it back.
    r1 = resp_seen[1];
    set_req(1, 1'b1, 8, 8'h3C);
    step();
    req_valid = '0;
    repeat (2) step();
    set_req(1, 1'b0, 8, 0);
    step();
    req_valid = '0;
    repeat (2) step();
    check("core1_resp_count", 32'(resp_seen[1] - r1), 32'd2);

    // Contention: both cores request continuously.
    base = hs_id.size();
    set_req(0, 1'b0, 5, 0);
    set_req(1, 1'b0, 9, 0);
    repeat (12) step();
    req_valid = '0;
    repeat (2) step();
    check("contention_grants", 32'(hs_id.size() - base), 32'd4);
    for (int k = 0; k < 4 && base + k < hs_id.size(); k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      check("contention_id", 32'(hs_id[base + k]), 32'd0);
`else
      check("contention_id", 32'(hs_id[base + k]), 32'(k % 2));
`endif
      if (k > 0) check("contention_spacing", 32'(hs_cyc[base + k] - hs_cyc[base + k - 1]), 32'd3);
    end

    // Dropped request: core1 pulses valid for one cycle while core0 is served.
    r1 = resp_seen[1];
    set_req(0, 1'b0, 2, 0);
    step();
    req_valid = '0;
    set_req(1, 1'b0, 4, 0);
    step();
    req_valid = '0;
    repeat (3) step();
    check("dropped_no_resp", 32'(resp_seen[1] - r1), 32'd0);

    // Reset while a read is in ISSUE.
    set_req(0, 1'b0, 6, 0);
    step();
    req_valid = '0;
    check("issue_before_reset", 32'(mem_read_en), 32'd1);
    reset = 1'b0;
    #1;
    check("reset_drops_read_en", 32'(mem_read_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    model_reset();
    step();
    reset = 1'b1;
    set_req(0, 1'b0, 7, 0);
    set_req(1, 1'b0, 7, 0);
    #1;
    check("after_reset_grant_core0", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    repeat (2) step();

    // Randomized traffic with drops and re-requests.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req_valid[i] && last_ready[i]) begin
          req_valid[i] = 1'b0;
          cool[i] = int'($urandom_range(0, 3));
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if (cool[i] > 0) cool[i]--;
          else if ($urandom_range(0, 2) == 0)
            set_req(i, 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end
      end
      step();
    end
    req_valid = '0;
    repeat (3) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter that shares the single-ported `shared_memory` among `NUM_CORES` requesting cores. Each core issues read/write requests over a valid/ready handshake; the arbiter grants one core at a time in round-robin order, drives the memory's enables, address and write data, and returns a one-cycle response to the granted core. It sits in `gpu_top` between the core array and `shared_memory`, replacing the direct per-core wiring.

## Interface
- `NUM_CORES`, 2: number of requesting cores, 2..8.
- `DATA_WIDTH`, 8: memory word width.
- `ADDR_WIDTH`, 4: memory address width.
- `CORE_ID_WIDTH`, `$clog2(NUM_CORES)`: width of grant index (derived, not overridden).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `req_valid` in NUM_CORES: per-core request valid.
- `req_ready` out NUM_CORES: per-core request accepted this cycle.
- `req_write` in NUM_CORES: 1 = write, 0 = read.
- `req_addr` in NUM_CORES*ADDR_WIDTH: packed addresses, core i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata` in NUM_CORES*DATA_WIDTH: packed write data, same packing.
- `resp_valid` out NUM_CORES: one-cycle completion pulse to the owning core.
- `resp_rdata` out DATA_WIDTH: read data, shared bus, valid only with `resp_valid`.
- `mem_read_en` out 1, `mem_write_en` out 1: memory enables.
- `mem_addr` out ADDR_WIDTH, `mem_write_data` out DATA_WIDTH: memory address and write data.
- `mem_read_data` in DATA_WIDTH: memory read data, valid the cycle after `mem_read_en`.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out CORE_ID_WIDTH: index of the current or last granted core.

## Operation
- FSM states: IDLE, ISSUE, RESP. Transitions: IDLE->ISSUE on any `req_valid`; ISSUE->RESP always; RESP->IDLE always.
- IDLE: combinational arbitration. Winner = first core with `req_valid` set, searching from `rr_ptr` upward, modulo NUM_CORES. `req_ready` is one-hot on the winner only, and only in IDLE. On handshake, latch owner, write flag, address and wdata.
- ISSUE: registered outputs assert exactly one of `mem_read_en`/`mem_write_en` for one cycle with the latched address/data. `rr_ptr` <= owner+1, wrapping NUM_CORES-1 to 0.
- RESP: for reads, `resp_rdata` <= `mem_read_data`. For writes, `resp_rdata` holds its previous value. `resp_valid[owner]` pulses for one cycle in both cases.
- Requests never pass through or queue. A core holds `req_valid` and its fields stable until `req_ready`. Deasserting `req_valid` before `req_ready` is legal; the request is simply dropped.
- A core may re-request in the cycle after `resp_valid`. It competes normally under round-robin.
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, all `mem_*` outputs 0, `busy`=0, `grant_id`=0, `rr_ptr`=0, state IDLE.
- Reset mid-operation: the in-flight access is abandoned immediately. No `resp_valid` is produced, and the memory enables drop asynchronously.

## Timing
- Handshake in cycle T; memory enable in T+1; `resp_valid` in T+2. The next grant is possible in T+3, so peak throughput is one access per 3 cycles.
- Latency from `req_valid` rising with no contention to `resp_valid` is 2 cycles.
- Worst-case wait for a continuously requesting core under full contention: 3*(NUM_CORES-1) cycles before its handshake.
- `mem_*` outputs and `resp_*` outputs are registered. `req_ready` is combinational from `req_valid`, `rr_ptr` and state.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest core index wins, and `rr_ptr` is not implemented.
  - Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- Shared package `gpu_pkg`: FSM state enum `arb_state_t` (IDLE, ISSUE, RESP) and a helper function for the round-robin priority search.
- One sub-module is natural: `rr_picker`, a combinational one-hot picker with inputs `req` and `ptr`, outputs `grant_onehot` and `grant_idx`.
- Under `MEM_ARB_FIXED_PRIO_EN`, `rr_picker` is instantiated with `ptr` tied to 0.

## Test plan
- Single read, NUM_CORES=2: memory[3]=0xA5; core0 reads addr 3 -> `req_ready[0]` at T, `mem_read_en`=1 with `mem_addr`=3 at T+1, `resp_valid[0]`=1 with `resp_rdata`=0xA5 at T+2.
- Write then read: core1 writes 0x3C to addr 8, then reads addr 8 -> `mem_write_en` pulse with data 0x3C; the read response returns 0x3C; `resp_valid[1]` pulses twice in total.
- Contention, round-robin: both cores hold `req_valid` from cycle 0 -> grants alternate 0,1,0,1 at cycles 0,3,6,9; `req_ready` is never two-hot.
- Fixed priority (`MEM_ARB_FIXED_PRIO_EN`): both cores hold `req_valid` -> core0 is granted at cycles 0,3,6 and core1 is never granted while core0 keeps requesting.
- Reset mid-operation: assert `reset`=0 in ISSUE -> `mem_read_en` drops within the same cycle; no `resp_valid` appears; after release, `busy`=0 and the next grant goes to core0.
- Dropped request: core1 pulses `req_valid` for 1 cycle while core0 is being served -> no grant and no response for core1; the FSM returns to IDLE.
